// File: rtl/ram_pkg.sv
// ram_pkg: constants shared by the RAM hierarchy (ram4 and the larger
// RAM stages that tile it).
//   RAM_WORD_W  - default word width in bits
//   RAM4_DEPTH  - number of words in one ram4
//   RAM4_ADDR_W - address width of one ram4
//   RESET_WORD  - value every word takes while rst_n is low
package ram_pkg;

    localparam int unsigned RAM_WORD_W  = 16;
    localparam int unsigned RAM4_DEPTH  = 4;
    localparam int unsigned RAM4_ADDR_W = 2;

    localparam logic [RAM_WORD_W-1:0] RESET_WORD = 16'h0000;

endpackage : ram_pkg

// File: rtl/ram4_dmux4.sv
// dmux4: 1-bit, four-way demultiplexer. Routes 'in' to the output bit
// selected by 'sel'; all other output bits are 0, so at most one output is
// ever high.
//   in  - bit to route (the RAM write enable)
//   sel - output select
//   out - one-hot (or all-zero) strobes
module dmux4
    import ram_pkg::*;
(
    input  logic                   in,
    input  logic [RAM4_ADDR_W-1:0] sel,
    output logic [RAM4_DEPTH-1:0]  out
);

    // Route the input bit to the selected strobe.
    always_comb begin
        out = 4'b0000;
        case (sel)
            2'd0:    out[0] = in;
            2'd1:    out[1] = in;
            2'd2:    out[2] = in;
            2'd3:    out[3] = in;
            default: out    = 4'b0000;
        endcase
    end

endmodule : dmux4

// File: rtl/ram4_word_reg.sv
// word_reg: WIDTH-bit storage word with load enable and asynchronous
// active-low clear to RESET_WORD.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low clear
//   ld    - load enable, sampled on the rising edge
//   d     - data to store
//   q     - stored word
module word_reg
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH = RAM_WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage: clear on reset, capture d when loaded, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= WIDTH'(RESET_WORD);
        end else if (ld) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule : word_reg

// File: rtl/ram4.sv
// ram4: four-word, WIDTH-bit random-access memory. 'load' is demultiplexed
// by 'address' into one-hot word strobes; the selected word captures 'in'
// on the rising edge. 'out' is a combinational read of the addressed word.
//   clk     - sole clock, rising edge
//   rst_n   - asynchronous active-low reset, clears all words
//   in      - write data
//   load    - write enable
//   address - word select for write and read
//   out     - contents of the addressed word
// Build option: define RAM4_BYPASS_EN for write-through, where 'out'
// follows 'in' combinationally whenever 'load' is high (never in reset).
module ram4
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH = RAM_WORD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in,
    input  logic                   load,
    input  logic [RAM4_ADDR_W-1:0] address,
    output logic [WIDTH-1:0]       out
);

    logic [RAM4_DEPTH-1:0] ld_s;
    logic [WIDTH-1:0]      mem_s [RAM4_DEPTH];
    logic [WIDTH-1:0]      rd_s;

    dmux4 u_dmux (
        .in  (load),
        .sel (address),
        .out (ld_s)
    );

    for (genvar k = 0; k < RAM4_DEPTH; k++) begin : g_word
        word_reg #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (ld_s[k]),
            .d     (in),
            .q     (mem_s[k])
        );
    end

    // Read mux: select the addressed stored word.
    always_comb begin
        rd_s = WIDTH'(RESET_WORD);
        case (address)
            2'd0:    rd_s = mem_s[0];
            2'd1:    rd_s = mem_s[1];
            2'd2:    rd_s = mem_s[2];
            2'd3:    rd_s = mem_s[3];
            default: rd_s = WIDTH'(RESET_WORD);
        endcase
    end

    // Output select: reset forces the reset word so the bypass path can
    // never leak write data while the memory is held cleared.
    always_comb begin
        out = rd_s;
        if (!rst_n) begin
            out = WIDTH'(RESET_WORD);
        end else begin
`ifdef RAM4_BYPASS_EN
            if (load) begin
                out = in;
            end else begin
                out = rd_s;
            end
`else
            out = rd_s;
`endif
        end
    end

endmodule : ram4

// File: tb/tb_ram4.sv
module tb_ram4;

    typedef struct {
        logic        ld;
        logic [1:0]  addr;
        logic [15:0] din;
        logic [15:0] old_val;   // stored value at addr before the edge
        logic [15:0] post_val;  // value at addr just after the edge
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic [1:0]  address;
    logic [15:0] out;

    int total;
    int bad;
    vec_t vecs[$];

    ram4 #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .load    (load),
        .address (address),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [1:0] a, input logic [15:0] d,
                       input logic [15:0] o, input logic [15:0] p);
        vec_t v;
        v.ld = ld; v.addr = a; v.din = d; v.old_val = o; v.post_val = p;
        vecs.push_back(v);
    endtask

    function automatic logic [15:0] pre_expect(input logic ld, input logic [15:0] d,
                                               input logic [15:0] o);
`ifdef RAM4_BYPASS_EN
        return ld ? d : o;
`else
        return o;
`endif
    endfunction

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b1;
        load    = 1'b0;
        in      = 16'h0000;
        address = 2'd0;
        #1 rst_n = 1'b0;

        // Reset held: writes ignored, every address reads 0.
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            load = 1'b1; in = 16'hFFFF; address = 2'(a);
            #1 check($sformatf("rst_pre_a%0d", a), out, 16'h0000);
            @(posedge clk);
            #1 check($sformatf("rst_post_a%0d", a), out, 16'h0000);
        end
        @(negedge clk);
        load = 1'b0;
        rst_n = 1'b1;

        // Vector table: write/readback, isolation, hold, same-cycle write/read.
        add(1'b1, 2'd0, 16'h1111, 16'h0000, 16'h1111);
        add(1'b1, 2'd1, 16'h2222, 16'h0000, 16'h2222);
        add(1'b1, 2'd2, 16'h3333, 16'h0000, 16'h3333);
        add(1'b1, 2'd3, 16'h4444, 16'h0000, 16'h4444);
        add(1'b0, 2'd0, 16'h0000, 16'h1111, 16'h1111);
        add(1'b0, 2'd1, 16'h0000, 16'h2222, 16'h2222);
        add(1'b0, 2'd2, 16'h0000, 16'h3333, 16'h3333);
        add(1'b0, 2'd3, 16'h0000, 16'h4444, 16'h4444);
        add(1'b1, 2'd2, 16'hBEEF, 16'h3333, 16'hBEEF);
        add(1'b0, 2'd0, 16'h0000, 16'h1111, 16'h1111);
        add(1'b0, 2'd1, 16'h0000, 16'h2222, 16'h2222);
        add(1'b0, 2'd3, 16'h0000, 16'h4444, 16'h4444);
        add(1'b0, 2'd2, 16'h0000, 16'hBEEF, 16'hBEEF);
        add(1'b0, 2'd1, 16'hDEAD, 16'h2222, 16'h2222);
        add(1'b0, 2'd1, 16'hDEAD, 16'h2222, 16'h2222);
        add(1'b0, 2'd1, 16'hDEAD, 16'h2222, 16'h2222);
        add(1'b1, 2'd3, 16'h5A5A, 16'h4444, 16'h5A5A);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            load = vecs[i].ld; address = vecs[i].addr; in = vecs[i].din;
            #1 check($sformatf("vec%0d_pre", i), out,
                     pre_expect(vecs[i].ld, vecs[i].din, vecs[i].old_val));
            @(posedge clk);
            #1 check($sformatf("vec%0d_post", i), out, vecs[i].post_val);
        end

        // Asynchronous reset between edges, during a pending write.
        @(negedge clk);
        load = 1'b1; address = 2'd0; in = 16'hAAAA;
        #2 rst_n = 1'b0;
        #1 check("async_rst_before_edge", out, 16'h0000);
        @(posedge clk);
        #1 check("async_rst_after_edge", out, 16'h0000);
        @(negedge clk);
        load = 1'b0;
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1 check($sformatf("after_rst_a%0d", a), out, 16'h0000);
        end

        // Reset released with a write pending: first edge applies it.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; load = 1'b1; address = 2'd1; in = 16'h7777;
        @(posedge clk);
        #1 check("release_pending_load", out, 16'h7777);
        @(negedge clk);
        load = 1'b0; address = 2'd2;
        #1 check("release_other_word", out, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ram4
